mcu_spi: RTL
============

Name: mcu_spi

Overview:
- SPI target front end between the board MCU and the system-control, HID, OSD and SD-card byte interfaces; it sits directly upstream of sysctrl.
- Oversamples MCU SPI mode 0 (MSB first) in the `clk` domain. The first byte of each chip-select frame is a target id; it routes every later byte to that target as a strobe/start/data triple.
- Returns each target's reply byte on MISO one byte later.

Parameters:
- TARGETS, 4: number of byte targets. The target id is the index into the `byte_strobe` and `reply_data` vectors.
- REPLY_DELAY, 2: clk cycles after `byte_strobe` before the selected `reply_data` is captured. This covers targets that register their reply.

Ports:
- clk  in  1  system clock; minimum 8 clk cycles per SCLK period
- reset_n  in  1  asynchronous, active-low reset
- spi_cs_n  in  1  MCU chip select, active low, asynchronous to clk
- spi_sclk  in  1  MCU SPI clock, asynchronous to clk
- spi_mosi  in  1  MCU data out
- spi_miso  out  1  data to MCU
- byte_strobe  out  TARGETS  one-hot, one-cycle pulse per received payload byte
- byte_start  out  1  valid with `byte_strobe`; 1 on the first payload byte (command byte) of a frame
- byte_data  out  8  received payload byte, valid with `byte_strobe`
- reply_data  in  8*TARGETS  reply byte from each target; slice t is bits [8t+7:8t]
- int_in  in  8  interrupt summary; used only with MCU_SPI_IRQ_STATUS_EN

Behaviour:
- Input sync: `spi_cs_n`, `spi_sclk` and `spi_mosi` each pass through 2-FF synchronisers. Edge detect uses the synchronised `spi_sclk` against its previous value. `spi_mosi` is sampled from the synchronised copy on a detected SCLK rising edge.
- Reset values: `spi_miso`=0, `byte_strobe`=0, `byte_start`=0, `byte_data`=8'h00, state=IDLE, bit counter=0, target=0.
- Reset mid-operation: any partial frame is dropped and no strobe is emitted.
- State machine: IDLE, TGT, PAYLOAD, DROP.
  - IDLE: leave to TGT on synchronised `spi_cs_n` falling. On that edge, load the TX shift register with the status byte (8'h00 without the option) and clear the bit counter.
  - TGT: the 8th rising edge completes the target id byte.
    - id < TARGETS: latch it, set first-byte flag, go to PAYLOAD.
    - Otherwise: go to DROP.
    - No strobe in either case.
  - PAYLOAD: the 8th rising edge completes a byte. In the next clk cycle:
    - `byte_strobe[target]`=1 for exactly one cycle.
    - `byte_data`=the received byte.
    - `byte_start`=first-byte flag; then clear the flag.
  - DROP: bits are clocked in but produce no strobes; MISO drives 0.
  - Any state: synchronised `spi_cs_n` rising goes to IDLE immediately. A partial byte is discarded with no strobe. Counter and first-byte flag clear.
- Bit counter: 3 bits, wraps 7->0 on each completed byte, so consecutive bytes need no gap.
- MISO, mode 0:
  - The shift register shifts left on each SCLK falling edge.
  - `spi_miso` = shift register MSB, registered.
  - Exactly REPLY_DELAY cycles after each `byte_strobe`, the register is loaded with `reply_data` slice [target]. That value is shifted out during the following byte (one-byte reply latency).
  - During the target byte and the first payload byte the MCU receives the status byte and 8'h00 respectively.
- Simultaneous events:
  - CS rising in the same cycle as a byte completion: the byte completes and strobes; the state still returns to IDLE.
  - A pending reply load after CS rising is cancelled.
- `spi_cs_n` high: `spi_miso` holds 0; no strobes.

Optional Feature:
- MCU_SPI_IRQ_STATUS_EN defined: the status byte shifted out during the target id byte is `int_in`, sampled on CS falling. The MCU reads the interrupt summary for free at frame start.
- Undefined: the status byte is 8'h00, `int_in` is unused, and no sampling register is built.

Decomposition:
- Shared package/include mcu_spi_pkg:
  - target ids TGT_SYS=0, TGT_HID=1, TGT_OSD=2, TGT_SDC=3;
  - state encodings IDLE/TGT/PAYLOAD/DROP;
  - default STATUS_NONE=8'h00.
- Sub-module spi_sync: 2-FF synchroniser plus rise/fall edge detector, instantiated for sclk and cs_n. MOSI uses the synchroniser only.

Test Plan:
- Frame {8'h00, 8'h03, 8'hAA}, SCLK = clk/10: `byte_strobe`=4'b0001 twice; first with `byte_start`=1, `byte_data`=8'h03; second with `byte_start`=0, `byte_data`=8'hAA.
- Target 0 holds `reply_data`[7:0]=8'h5C after the first payload byte: the MCU reads 8'h5C on MISO during the third byte. MISO reads 8'h00 during the first two bytes.
- Frame {8'h07, 8'h11} with TARGETS=4: no strobes, MISO constant 0, next frame to target 1 works normally.
- CS rises after 5 bits of a payload byte: no strobe. A following frame {8'h02, 8'h01} gives `byte_strobe`=4'b0100, `byte_start`=1, `byte_data`=8'h01.
- `reset_n` asserted mid-byte: all outputs 0 asynchronously; after release, a clean frame decodes correctly.
- MCU_SPI_IRQ_STATUS_EN with `int_in`=8'h81: the MCU reads 8'h81 during the target byte. Without the macro it reads 8'h00.

Source files
------------

// File: rtl/mcu_spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the mcu_spi target front end: target ids, FSM states, default status.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TGT     = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } spi_state_t;

    localparam logic [7:0] TGT_SYS = 8'd0;
    localparam logic [7:0] TGT_HID = 8'd1;
    localparam logic [7:0] TGT_OSD = 8'd2;
    localparam logic [7:0] TGT_SDC = 8'd3;

    localparam logic [7:0] STATUS_NONE = 8'h00;

endpackage

// File: rtl/mcu_spi_if.sv
`timescale 1ns/1ps
// MCU SPI pins plus the per-target byte strobe/data/reply bus of mcu_spi.
interface mcu_spi_if #(
    parameter int unsigned TARGETS = 4
);
    logic                   spi_cs_n;
    logic                   spi_sclk;
    logic                   spi_mosi;
    logic                   spi_miso;
    logic [TARGETS-1:0]     byte_strobe;
    logic                   byte_start;
    logic [7:0]             byte_data;
    logic [8*TARGETS-1:0]   reply_data;
    logic [7:0]             int_in;

    modport slave (
        input  spi_cs_n, spi_sclk, spi_mosi, reply_data, int_in,
        output spi_miso, byte_strobe, byte_start, byte_data
    );

    modport master (
        output spi_cs_n, spi_sclk, spi_mosi, reply_data, int_in,
        input  spi_miso, byte_strobe, byte_start, byte_data
    );
endinterface

// File: rtl/spi_sync.sv
`timescale 1ns/1ps
// 2-FF synchroniser with a third register for rise/fall detection of the synchronised level.
module spi_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    // ff[1:0] synchronise, ff[2] holds the previous synchronised level
    logic [2:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {3{RESET_VAL}};
        end else begin
            ff <= {ff[1:0], d};
        end
    end

    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];
endmodule

// File: rtl/mcu_spi.sv
`timescale 1ns/1ps
// mcu_spi: oversampled SPI mode-0 target; first byte of a frame selects the byte target.
// Define MCU_SPI_IRQ_STATUS_EN to shift int_in out as the status byte during the target id byte.
module mcu_spi
    import mcu_spi_pkg::*;
#(
    parameter int unsigned TARGETS     = 4,
    parameter int unsigned REPLY_DELAY = 2
) (
    input  logic     clk,
    input  logic     reset_n,
    mcu_spi_if.slave bus
);
    localparam int unsigned   TW        = (TARGETS > 1) ? $clog2(TARGETS) : 1;
    localparam int unsigned   DW        = $clog2(REPLY_DELAY + 1) + 1;
    localparam logic [7:0]    TARGETS_B = 8'(TARGETS);
    localparam logic [DW-1:0] DLY_LOAD  = DW'(REPLY_DELAY);

    spi_state_t         state, state_next;
    logic               sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [1:0]         mosi_ff;
    logic               mosi_s;
    logic [2:0]         bit_cnt;
    logic [6:0]         rx_sr;
    logic [7:0]         rx_byte;
    logic [TW-1:0]      target;
    logic               first;
    logic [8:0]         tx_sr, tx_next;
    logic               miso_next;
    logic [DW-1:0]      dly;
    logic               byte_done, payload_done, id_ok;
    logic [TARGETS-1:0] strobe_next;
    logic [7:0]         reply_sel, status_byte;

    spi_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (bus.spi_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (bus.spi_cs_n),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    assign mosi_s = mosi_ff[1];

`ifdef MCU_SPI_IRQ_STATUS_EN
    assign status_byte = bus.int_in;
`else
    logic unused_int_in;
    assign status_byte   = STATUS_NONE;
    assign unused_int_in = ^bus.int_in;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        rx_byte      = {rx_sr, mosi_s};
        byte_done    = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
        id_ok        = rx_byte < TARGETS_B;
        payload_done = byte_done && (state == PAYLOAD);
        unique case (state)
            IDLE:    if (cs_fall) state_next = TGT;
            TGT:     if (byte_done) state_next = id_ok ? PAYLOAD : DROP;
            default: ;
        endcase
        if (cs_rise) state_next = IDLE;
    end

    always_comb begin
        strobe_next         = '0;
        strobe_next[target] = payload_done;
        reply_sel           = '0;
        for (int unsigned t = 0; t < TARGETS; t++) begin
            if (target == TW'(t)) reply_sel = bus.reply_data[8*t +: 8];
        end
        // tx_sr[8] drives MISO; replies land in [7:0] so the next SCLK fall exposes their MSB
        tx_next = tx_sr;
        if (state == IDLE) begin
            if (cs_fall) tx_next = {status_byte, 1'b0};
        end else begin
            if (sclk_fall) tx_next = {tx_sr[7:0], 1'b0};
            if (dly == DW'(1)) tx_next[7:0] = reply_sel;
        end
        miso_next = ((state_next == TGT) || (state_next == PAYLOAD)) && tx_next[8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_ff         <= '0;
            bit_cnt         <= '0;
            rx_sr           <= '0;
            target          <= '0;
            first           <= 1'b0;
            tx_sr           <= '0;
            dly             <= '0;
            bus.spi_miso    <= 1'b0;
            bus.byte_strobe <= '0;
            bus.byte_start  <= 1'b0;
            bus.byte_data   <= '0;
        end else begin
            mosi_ff         <= {mosi_ff[0], bus.spi_mosi};
            tx_sr           <= tx_next;
            bus.spi_miso    <= miso_next;
            // a byte completing together with CS rising still strobes
            bus.byte_strobe <= strobe_next;
            bus.byte_start  <= payload_done && first;
            if (payload_done) bus.byte_data <= rx_byte;

            if (cs_rise) begin
                bit_cnt <= '0;
                first   <= 1'b0;
                dly     <= '0;
            end else begin
                if (state == IDLE) begin
                    if (cs_fall) bit_cnt <= '0;
                end else if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sr   <= rx_byte[6:0];
                end
                if ((state == TGT) && byte_done && id_ok) begin
                    target <= rx_byte[TW-1:0];
                    first  <= 1'b1;
                end
                if (payload_done) begin
                    first <= 1'b0;
                    dly   <= DLY_LOAD;
                end else if (dly != '0) begin
                    dly <= dly - DW'(1);
                end
            end
        end
    end
endmodule
